// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// The sequencer FSM states and the width rule for its single shared counter.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        SYNC,
        HOLD,
        WAIT_RDY,
        DONE,
        SW_ASSERT
    } seq_state_e;

    // One counter serves both the hold and the ready-timeout windows.
    function automatic int ctr_width(input int hold_cycles, input int timeout_cycles);
        int max_cycles;
        max_cycles = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
        return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Board-reset synchronizer: asserts asynchronously, releases after STAGES edges.
// rel_next_o flags that the final stage drops on the coming edge.
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic rst_o,
    output logic rel_next_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b0};
        end
    end

    assign rst_o      = sync_q[STAGES-1];
    assign rel_next_o = ~sync_q[STAGES-2];

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: synchronizes board reset, then releases each domain
// reset in index order with a fixed hold and an optional ready handshake.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS    = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sw_reset_req,
    input  logic [NUM_DOMAINS-1:0]         dom_ready,
    output logic [NUM_DOMAINS-1:0]         dom_reset,
    output logic                           seq_busy,
    output logic                           seq_done,
    output logic                           timeout_err,
    output logic [$clog2(NUM_DOMAINS):0]   cur_stage
);

    localparam int STAGE_W = $clog2(NUM_DOMAINS) + 1;
    localparam int CTR_W   = ctr_width(HOLD_CYCLES, TIMEOUT_CYCLES);

    localparam logic [CTR_W-1:0]   HOLD_LAST  = CTR_W'(HOLD_CYCLES - 1);
    localparam logic [CTR_W-1:0]   TO_LAST    = CTR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_DOMAINS - 1);
    localparam bit                 HANDSHAKE  = (TIMEOUT_CYCLES > 0);

    seq_state_e               state_q, state_d;
    logic [CTR_W-1:0]         ctr_q, ctr_d;
    logic [STAGE_W-1:0]       stage_q, stage_d;
    logic [NUM_DOMAINS-1:0]   dom_reset_q, dom_reset_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic                     rst_sync;
    logic                     rel_next;
    logic [NUM_DOMAINS-1:0]   stage_sel;
    logic                     ready_hit;
    logic                     advance;

    reset_sync #(
        .STAGES     (SYNC_STAGES)
    ) u_reset_sync (
        .clk_i      (clk),
        .rst_i      (reset),
        .rst_o      (rst_sync),
        .rel_next_o (rel_next)
    );

    assign stage_sel = NUM_DOMAINS'(1) << stage_q;
    assign ready_hit = |(dom_ready & stage_sel);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        stage_d     = stage_q;
        dom_reset_d = dom_reset_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        advance     = 1'b0;

        case (state_q)
            SYNC: begin
                // Leave on the same edge that the synchronizer output drops.
                if (rel_next && rst_sync) begin
                    state_d = HOLD;
                    ctr_d   = '0;
                end
            end
            HOLD: begin
                if (ctr_q == HOLD_LAST) begin
                    dom_reset_d = dom_reset_q & ~stage_sel;
                    ctr_d       = '0;
                    if (HANDSHAKE) state_d = WAIT_RDY;
                    else           advance = 1'b1;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            WAIT_RDY: begin
                if (ready_hit) begin
                    advance = 1'b1;
                end else if (ctr_q == TO_LAST) begin
                    err_d   = 1'b1;
                    advance = 1'b1;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            SW_ASSERT: begin
                if (ctr_q == HOLD_LAST) begin
                    state_d = HOLD;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            DONE: begin
            end
            default: begin
                state_d = SYNC;
            end
        endcase

        if (advance) begin
            ctr_d = '0;
            if (stage_q == LAST_STAGE) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                stage_d = stage_q + 1'b1;
                state_d = HOLD;
            end
        end

        // Software re-reset overrides whatever the state decided this edge.
        if (sw_reset_req && (state_q != SYNC)) begin
            state_d     = SW_ASSERT;
            ctr_d       = '0;
            stage_d     = '0;
            dom_reset_d = '1;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SYNC;
            ctr_q       <= '0;
            stage_q     <= '0;
            dom_reset_q <= '1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            stage_q     <= stage_d;
            dom_reset_q <= dom_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign dom_reset   = dom_reset_q;
    assign seq_busy    = busy_q;
    assign seq_done    = done_q;
    assign timeout_err = err_q;
    assign cur_stage   = stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expected checkpoints are queued per edge
// and popped when the run reaches that edge. dut_b is the no-handshake variant.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sw_a = 1'b0;
    logic       sw_b = 1'b0;
    logic [2:0] rdy_a = 3'b111;
    logic [2:0] rdy_b = 3'b000;

    logic [2:0] dr_a, dr_b;
    logic       busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [2:0] stage_a, stage_b;
    logic [8:0] obs_a, obs_b;

    typedef struct {
        bit         dut_b;
        int         edge_no;
        string      tag;
        logic [8:0] exp;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_DOMAINS(3), .SYNC_STAGES(2), .HOLD_CYCLES(4), .TIMEOUT_CYCLES(8)
    ) dut_a (
        .clk(clk), .reset(reset), .sw_reset_req(sw_a), .dom_ready(rdy_a),
        .dom_reset(dr_a), .seq_busy(busy_a), .seq_done(done_a),
        .timeout_err(err_a), .cur_stage(stage_a)
    );

    reset_sequencer #(
        .NUM_DOMAINS(3), .SYNC_STAGES(2), .HOLD_CYCLES(4), .TIMEOUT_CYCLES(0)
    ) dut_b (
        .clk(clk), .reset(reset), .sw_reset_req(sw_b), .dom_ready(rdy_b),
        .dom_reset(dr_b), .seq_busy(busy_b), .seq_done(done_b),
        .timeout_err(err_b), .cur_stage(stage_b)
    );

    assign obs_a = {dr_a, busy_a, done_a, err_a, stage_a};
    assign obs_b = {dr_b, busy_b, done_b, err_b, stage_b};

    // Queue one expected snapshot {dom_reset, busy, done, err, stage}; edge -1 = now.
    task automatic expect_at(input bit dut_b_sel, input int edge_no, input string tag,
                             input logic [2:0] dr, input logic busy, input logic done,
                             input logic err, input logic [2:0] st);
        exp_t e;
        e.dut_b   = dut_b_sel;
        e.edge_no = edge_no;
        e.tag     = tag;
        e.exp     = {dr, busy, done, err, st};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t       e;
        logic [8:0] obs;
        e   = sb.pop_front();
        obs = e.dut_b ? obs_b : obs_a;
        vectors++;
        assert (obs === e.exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (dom_reset,busy,done,err,stage)",
                   e.tag, obs, e.exp);
        end
    endtask

    task automatic run_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            edge_cnt++;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].edge_no == edge_cnt) check();
        end
    endtask

    task automatic flush(input string scen);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $error("FAIL %s: checkpoint %s at edge %0d not reached (observed none, expected %b)",
                   scen, e.tag, e.edge_no, e.exp);
        end
    endtask

    task automatic assert_reset(input string tag);
        reset = 1'b1;
        #1;
        expect_at(0, -1, {tag, "_a"}, 3'b111, 1'b1, 1'b0, 1'b0, 3'd0);
        check();
        expect_at(1, -1, {tag, "_b"}, 3'b111, 1'b1, 1'b0, 1'b0, 3'd0);
        check();
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        edge_cnt = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        assert_reset(tag);
        release_reset();
    endtask

    initial begin
        // Scenario 1 (dut_a, ready tied high) alongside scenario 6 (dut_b, no handshake).
        rdy_a = 3'b111;
        rdy_b = 3'b000;
        do_reset("s1_rst");
        expect_at(0,  2, "s1_e2",   3'b111, 1, 0, 0, 3'd0);
        expect_at(0,  5, "s1_e5",   3'b111, 1, 0, 0, 3'd0);
        expect_at(1,  5, "s6_e5",   3'b111, 1, 0, 0, 3'd0);
        expect_at(0,  6, "s1_e6",   3'b110, 1, 0, 0, 3'd0);
        expect_at(1,  6, "s6_e6",   3'b110, 1, 0, 0, 3'd1);
        expect_at(1,  9, "s6_e9",   3'b110, 1, 0, 0, 3'd1);
        expect_at(0, 10, "s1_e10",  3'b110, 1, 0, 0, 3'd1);
        expect_at(1, 10, "s6_e10",  3'b100, 1, 0, 0, 3'd2);
        expect_at(0, 11, "s1_e11",  3'b100, 1, 0, 0, 3'd1);
        expect_at(1, 13, "s6_e13",  3'b100, 1, 0, 0, 3'd2);
        expect_at(1, 14, "s6_e14",  3'b000, 0, 1, 0, 3'd2);
        expect_at(0, 15, "s1_e15",  3'b100, 1, 0, 0, 3'd2);
        expect_at(0, 16, "s1_e16",  3'b000, 1, 0, 0, 3'd2);
        expect_at(1, 16, "s6_e16",  3'b000, 0, 1, 0, 3'd2);
        expect_at(0, 17, "s1_e17",  3'b000, 0, 1, 0, 3'd2);
        expect_at(0, 20, "s1_e20",  3'b000, 0, 1, 0, 3'd2);
        run_edges(20);
        flush("s1");

        // Scenario 2: domain 1 never acknowledges.
        rdy_a = 3'b101;
        do_reset("s2_rst");
        expect_at(0,  6, "s2_e6",   3'b110, 1, 0, 0, 3'd0);
        expect_at(0, 11, "s2_e11",  3'b100, 1, 0, 0, 3'd1);
        expect_at(0, 18, "s2_e18",  3'b100, 1, 0, 0, 3'd1);
        expect_at(0, 19, "s2_e19",  3'b100, 1, 0, 1, 3'd2);
        expect_at(0, 22, "s2_e22",  3'b100, 1, 0, 1, 3'd2);
        expect_at(0, 23, "s2_e23",  3'b000, 1, 0, 1, 3'd2);
        expect_at(0, 24, "s2_e24",  3'b000, 0, 1, 1, 3'd2);
        run_edges(24);
        flush("s2");

        // Scenario 3: software re-reset ten cycles after done.
        rdy_a = 3'b111;
        expect_at(0, 33, "s3_e33",  3'b000, 0, 1, 1, 3'd2);
        run_edges(9);
        sw_a = 1'b1;
        expect_at(0, 34, "s3_sw",   3'b111, 1, 0, 0, 3'd0);
        run_edges(1);
        sw_a = 1'b0;
        expect_at(0, 37, "s3_e37",  3'b111, 1, 0, 0, 3'd0);
        expect_at(0, 41, "s3_e41",  3'b111, 1, 0, 0, 3'd0);
        expect_at(0, 42, "s3_e42",  3'b110, 1, 0, 0, 3'd0);
        expect_at(0, 47, "s3_e47",  3'b100, 1, 0, 0, 3'd1);
        expect_at(0, 51, "s3_e51",  3'b100, 1, 0, 0, 3'd2);
        expect_at(0, 52, "s3_e52",  3'b000, 1, 0, 0, 3'd2);
        expect_at(0, 53, "s3_e53",  3'b000, 0, 1, 0, 3'd2);
        run_edges(20);
        flush("s3");

        // Scenario 4: async reset between edges while stage 1 waits for ready.
        rdy_a = 3'b101;
        do_reset("s4_rst");
        expect_at(0, 11, "s4_e11",  3'b100, 1, 0, 0, 3'd1);
        run_edges(14);
        #2;
        assert_reset("s4_async");
        rdy_a = 3'b111;
        release_reset();
        expect_at(0,  5, "s4_e5",   3'b111, 1, 0, 0, 3'd0);
        expect_at(0,  6, "s4_e6",   3'b110, 1, 0, 0, 3'd0);
        expect_at(0, 11, "s4_e11b", 3'b100, 1, 0, 0, 3'd1);
        expect_at(0, 16, "s4_e16",  3'b000, 1, 0, 0, 3'd2);
        expect_at(0, 17, "s4_e17",  3'b000, 0, 1, 0, 3'd2);
        run_edges(18);
        flush("s4");

        // Scenario 5a: re-reset on the stage-2 hold expiry edge.
        do_reset("s5_rst");
        expect_at(0, 15, "s5_e15",  3'b100, 1, 0, 0, 3'd2);
        run_edges(15);
        sw_a = 1'b1;
        expect_at(0, 16, "s5_sw",   3'b111, 1, 0, 0, 3'd0);
        run_edges(1);
        sw_a = 1'b0;
        expect_at(0, 19, "s5_e19",  3'b111, 1, 0, 0, 3'd0);
        expect_at(0, 23, "s5_e23",  3'b111, 1, 0, 0, 3'd0);
        expect_at(0, 24, "s5_e24",  3'b110, 1, 0, 0, 3'd0);
        run_edges(10);
        flush("s5a");

        // Scenario 5b: request during synchronization is ignored.
        do_reset("s5b_rst");
        sw_a = 1'b1;
        expect_at(0,  1, "s5b_e1",  3'b111, 1, 0, 0, 3'd0);
        expect_at(0,  2, "s5b_e2",  3'b111, 1, 0, 0, 3'd0);
        run_edges(2);
        sw_a = 1'b0;
        expect_at(0,  5, "s5b_e5",  3'b111, 1, 0, 0, 3'd0);
        expect_at(0,  6, "s5b_e6",  3'b110, 1, 0, 0, 3'd0);
        expect_at(0, 11, "s5b_e11", 3'b100, 1, 0, 0, 3'd1);
        run_edges(12);
        flush("s5b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
